// File: rtl/seq_control_unit_if.sv
// Handshake bundle between the sequencer and its datapath/memories.
// Signal prefixes (i_/o_) are from the control unit's point of view.
interface seq_control_unit_if #(
    parameter int unsigned OPW   = 6,
    parameter int unsigned FUNCW = 4
);
    logic [OPW-1:0]   i_opcode;
    logic [FUNCW-1:0] i_func;
    logic             i_im_ready;
    logic             i_dm_ready;
    logic             i_flag_n;
    logic             i_flag_z;
    logic             i_resume;

    logic             o_rd_im;
    logic             o_ld_npc;
    logic             o_ld_ir;
    logic             o_rd_rp;
    logic             o_ld_a;
    logic             o_ld_b;
    logic             o_ld_imm;
    logic             o_imm_sel;
    logic             o_alu_src1;
    logic             o_alu_src2;
    logic             o_ld_aluout;
    logic             o_rd_dm;
    logic             o_wr_dm;
    logic             o_ld_lmd;
    logic             o_wr_rp;
    logic             o_ld_pc;
    logic             o_pc_sel;
    logic             o_halted;
    logic             o_illegal;
    logic             o_mem_timeout;
    logic [FUNCW-1:0] o_alu_func;
    logic [1:0]       o_wb_sel;

    modport master (
        input  i_opcode, i_func, i_im_ready, i_dm_ready, i_flag_n, i_flag_z, i_resume,
        output o_rd_im, o_ld_npc, o_ld_ir, o_rd_rp, o_ld_a, o_ld_b, o_ld_imm, o_imm_sel,
               o_alu_src1, o_alu_src2, o_ld_aluout, o_rd_dm, o_wr_dm, o_ld_lmd, o_wr_rp,
               o_ld_pc, o_pc_sel, o_halted, o_illegal, o_mem_timeout, o_alu_func, o_wb_sel
    );

    modport slave (
        output i_opcode, i_func, i_im_ready, i_dm_ready, i_flag_n, i_flag_z, i_resume,
        input  o_rd_im, o_ld_npc, o_ld_ir, o_rd_rp, o_ld_a, o_ld_b, o_ld_imm, o_imm_sel,
               o_alu_src1, o_alu_src2, o_ld_aluout, o_rd_dm, o_wr_dm, o_ld_lmd, o_wr_rp,
               o_ld_pc, o_pc_sel, o_halted, o_illegal, o_mem_timeout, o_alu_func, o_wb_sel
    );
endinterface

// File: rtl/seq_control_unit.sv
// Multi-cycle sequencer: FETCH/DECODE/EXEC/MEM/WB/HALT with memory-wait timeout.
// All strobes are combinational from state, latched instruction class and ready inputs.
module seq_control_unit #(
    parameter int unsigned OPW   = 6,
    parameter int unsigned FUNCW = 4,
    parameter int unsigned TOW   = 4
) (
    input logic                clk,
    input logic                rst,
    seq_control_unit_if.master bus
);

    localparam logic [2:0] StFetch  = 3'd0;
    localparam logic [2:0] StDecode = 3'd1;
    localparam logic [2:0] StExec   = 3'd2;
    localparam logic [2:0] StMem    = 3'd3;
    localparam logic [2:0] StWb     = 3'd4;
    localparam logic [2:0] StHalt   = 3'd5;

    localparam logic [3:0] ClsAlu  = 4'd0;
    localparam logic [3:0] ClsLd   = 4'd1;
    localparam logic [3:0] ClsSt   = 4'd2;
    localparam logic [3:0] ClsBr   = 4'd3;
    localparam logic [3:0] ClsBmi  = 4'd4;
    localparam logic [3:0] ClsBpl  = 4'd5;
    localparam logic [3:0] ClsBz   = 4'd6;
    localparam logic [3:0] ClsMove = 4'd7;
    localparam logic [3:0] ClsHalt = 4'd8;
    localparam logic [3:0] ClsNop  = 4'd9;
    localparam logic [3:0] ClsCmov = 4'd10;
    localparam logic [3:0] ClsImm  = 4'd11;
    localparam logic [3:0] ClsLui  = 4'd12;
    localparam logic [3:0] ClsIll  = 4'd13;

    function automatic logic [3:0] f_decode(input logic [OPW-1:0] op);
        logic [5:0] op6;
        op6 = op[5:0];
        if ((op >> 6) != '0) return ClsIll;
        case (op6)
            6'b000000: return ClsAlu;
            6'b000001: return ClsLd;
            6'b000010: return ClsSt;
            6'b000011: return ClsBr;
            6'b000100: return ClsBmi;
            6'b000101: return ClsBpl;
            6'b000110: return ClsBz;
            6'b000111: return ClsMove;
            6'b001000: return ClsHalt;
            6'b001001: return ClsNop;
            6'b101010: return ClsCmov;
            6'b111111: return ClsLui;
            default:   return (op6 >= 6'b110000 && op6 <= 6'b111001) ? ClsImm : ClsIll;
        endcase
    endfunction

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic [TOW-1:0]   r_wait;
    logic [TOW-1:0]   w_wait_nxt;
    logic [3:0]       r_cls;
    logic [3:0]       r_op4;
    logic [FUNCW-1:0] r_func;
    logic [3:0]       w_cls_dec;
    logic             w_timeout;
    logic             w_is_br;

    assign w_cls_dec = f_decode(bus.i_opcode);
    assign w_timeout = &r_wait;
    assign w_is_br   = (r_cls >= ClsBr) && (r_cls <= ClsBz);

    // Instruction fields are captured in DECODE; later states never look at the IR again.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StFetch;
            r_wait  <= '0;
            r_cls   <= ClsNop;
            r_op4   <= '0;
            r_func  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_wait  <= w_wait_nxt;
            if (r_state == StDecode) begin
                r_cls  <= w_cls_dec;
                r_op4  <= bus.i_opcode[3:0];
                r_func <= bus.i_func;
            end
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_wait_nxt        = '0;
        bus.o_rd_im       = 1'b0;
        bus.o_ld_npc      = 1'b0;
        bus.o_ld_ir       = 1'b0;
        bus.o_rd_rp       = 1'b0;
        bus.o_ld_a        = 1'b0;
        bus.o_ld_b        = 1'b0;
        bus.o_ld_imm      = 1'b0;
        bus.o_imm_sel     = 1'b0;
        bus.o_alu_src1    = 1'b0;
        bus.o_alu_src2    = 1'b0;
        bus.o_ld_aluout   = 1'b0;
        bus.o_rd_dm       = 1'b0;
        bus.o_wr_dm       = 1'b0;
        bus.o_ld_lmd      = 1'b0;
        bus.o_wr_rp       = 1'b0;
        bus.o_ld_pc       = 1'b0;
        bus.o_pc_sel      = 1'b0;
        bus.o_halted      = 1'b0;
        bus.o_illegal     = 1'b0;
        bus.o_mem_timeout = 1'b0;
        bus.o_alu_func    = '0;
        bus.o_wb_sel      = 2'b00;

        // Outputs stay at their quiet defaults for as long as reset is held.
        if (!rst) begin
            case (r_state)
                StFetch: begin
                    if (bus.i_im_ready) begin
                        bus.o_rd_im  = 1'b1;
                        bus.o_ld_npc = 1'b1;
                        bus.o_ld_ir  = 1'b1;
                        w_state_nxt  = StDecode;
                    end else if (w_timeout) begin
                        bus.o_mem_timeout = 1'b1;
                        w_state_nxt       = StHalt;
                    end else begin
                        bus.o_rd_im = 1'b1;
                        w_wait_nxt  = r_wait + TOW'(1);
                    end
                end

                StDecode: begin
                    w_state_nxt = StExec;
                    unique case (w_cls_dec)
                        ClsAlu: begin
                            bus.o_rd_rp = 1'b1;
                            bus.o_ld_a  = 1'b1;
                            bus.o_ld_b  = 1'b1;
                        end
                        ClsImm, ClsLui, ClsBmi, ClsBpl, ClsBz: begin
                            bus.o_rd_rp  = 1'b1;
                            bus.o_ld_a   = 1'b1;
                            bus.o_ld_imm = 1'b1;
                        end
                        ClsLd, ClsSt: begin
                            bus.o_rd_rp  = 1'b1;
                            bus.o_ld_a   = 1'b1;
                            bus.o_ld_b   = 1'b1;
                            bus.o_ld_imm = 1'b1;
                        end
                        ClsBr: begin
                            bus.o_ld_imm  = 1'b1;
                            bus.o_imm_sel = 1'b1;
                        end
                        ClsMove: bus.o_ld_a = 1'b1;
                        ClsCmov: begin
                            bus.o_ld_a = 1'b1;
                            bus.o_ld_b = 1'b1;
                        end
                        ClsHalt: w_state_nxt = StHalt;
                        ClsNop: begin
                            bus.o_ld_pc = 1'b1;
                            w_state_nxt = StFetch;
                        end
                        default: begin
                            bus.o_illegal = 1'b1;
                            bus.o_ld_pc   = 1'b1;
                            w_state_nxt   = StFetch;
                        end
                    endcase
                end

                StExec: begin
                    bus.o_alu_src2  = (r_cls != ClsAlu);
                    bus.o_ld_aluout = (r_cls == ClsAlu) || (r_cls == ClsImm) || (r_cls == ClsLui) ||
                                      (r_cls == ClsLd) || (r_cls == ClsSt) || w_is_br;
                    if (r_cls == ClsAlu) begin
                        bus.o_alu_func = r_func;
                    end else if ((r_cls == ClsImm) || (r_cls == ClsLui)) begin
                        bus.o_alu_func = FUNCW'(r_op4);
                    end
                    if (w_is_br) begin
                        bus.o_alu_src1 = 1'b1;
                        bus.o_ld_pc    = 1'b1;
                        w_state_nxt    = StFetch;
                        unique case (r_cls)
                            ClsBr:   bus.o_pc_sel = 1'b1;
                            ClsBmi:  bus.o_pc_sel = bus.i_flag_n;
                            ClsBpl:  bus.o_pc_sel = !bus.i_flag_n && !bus.i_flag_z;
                            default: bus.o_pc_sel = bus.i_flag_z;
                        endcase
                    end else if ((r_cls == ClsLd) || (r_cls == ClsSt)) begin
                        w_state_nxt = StMem;
                    end else begin
                        w_state_nxt = StWb;
                    end
                end

                StMem: begin
                    if (bus.i_dm_ready) begin
                        if (r_cls == ClsLd) begin
                            bus.o_rd_dm  = 1'b1;
                            bus.o_ld_lmd = 1'b1;
                            w_state_nxt  = StWb;
                        end else begin
                            bus.o_wr_dm = 1'b1;
                            bus.o_ld_pc = 1'b1;
                            w_state_nxt = StFetch;
                        end
                    end else if (w_timeout) begin
                        bus.o_mem_timeout = 1'b1;
                        w_state_nxt       = StHalt;
                    end else begin
                        bus.o_rd_dm = (r_cls == ClsLd);
                        bus.o_wr_dm = (r_cls != ClsLd);
                        w_wait_nxt  = r_wait + TOW'(1);
                    end
                end

                StWb: begin
                    bus.o_wr_rp = 1'b1;
                    bus.o_ld_pc = 1'b1;
                    w_state_nxt = StFetch;
                    unique case (r_cls)
                        ClsLd:   bus.o_wb_sel = 2'b00;
                        ClsMove: bus.o_wb_sel = 2'b10;
                        ClsCmov: bus.o_wb_sel = 2'b11;
                        default: bus.o_wb_sel = 2'b01;
                    endcase
                end

                StHalt: begin
                    bus.o_halted = 1'b1;
                    if (bus.i_resume) begin
                        bus.o_ld_pc = 1'b1;
                        w_state_nxt = StFetch;
                    end
                end

                default: w_state_nxt = StFetch;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_control_unit.sv
// Bench for seq_control_unit: directed vector table, hand-written corner sequences,
// and random instructions scored against a per-instruction summary model.
module tb_seq_control_unit;

    logic clk = 1'b0;
    logic rst;
    int   n_chk;
    int   n_fail;

    always #5 clk = ~clk;

    seq_control_unit_if #(.OPW(6), .FUNCW(4)) bus ();

    seq_control_unit #(.OPW(6), .FUNCW(4), .TOW(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        int       cycles;
        int       n_ldpc;
        int       n_ldir;
        int       n_rdim;
        int       n_wrrp;
        int       n_ill;
        int       n_aluout;
        int       n_rddm;
        int       n_wrdm;
        int       n_lmd;
        int       n_tmo;
        int       n_halt;
        logic     pcsel;
        logic [1:0] wbsel;
        logic [3:0] aluf;
    } stats_t;

    typedef struct {
        logic [5:0] op;
        logic [3:0] fn;
        logic       fneg;
        logic       fz;
        int         cycles;
        logic       pcsel;
        int         wrrp;
        logic [1:0] wbsel;
        int         ill;
        logic [3:0] aluf;
    } vec_t;

    function automatic logic [25:0] outs();
        return {bus.o_rd_im, bus.o_ld_npc, bus.o_ld_ir, bus.o_rd_rp, bus.o_ld_a, bus.o_ld_b,
                bus.o_ld_imm, bus.o_imm_sel, bus.o_alu_src1, bus.o_alu_src2, bus.o_ld_aluout,
                bus.o_rd_dm, bus.o_wr_dm, bus.o_ld_lmd, bus.o_wr_rp, bus.o_ld_pc, bus.o_pc_sel,
                bus.o_halted, bus.o_illegal, bus.o_mem_timeout, bus.o_alu_func, bus.o_wb_sel};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    // Expected per-instruction summary, derived from the opcode class rules alone.
    function automatic stats_t model(input logic [5:0] op, input logic [3:0] fn,
                                     input logic fneg, input logic fz,
                                     input int iw, input int dw);
        stats_t e;
        bit is_imm;
        bit is_br;
        bit legal;
        e      = '0;
        is_imm = (op >= 6'd48 && op <= 6'd57) || (op == 6'd63);
        is_br  = (op >= 6'd3 && op <= 6'd6);
        legal  = (op <= 6'd9) || (op == 6'd42) || is_imm;
        e.n_ldpc = 1;
        e.n_ldir = 1;
        e.n_rdim = iw + 1;
        if (!legal) begin
            e.cycles = 2;
            e.n_ill  = 1;
        end else if (op == 6'd9) begin
            e.cycles = 2;
        end else if (op == 6'd8) begin
            e.cycles = 3;
            e.n_halt = 1;
        end else if (is_br) begin
            e.cycles   = 3;
            e.n_aluout = 1;
            e.pcsel    = (op == 6'd3) || (op == 6'd4 && fneg) ||
                         (op == 6'd5 && !fneg && !fz) || (op == 6'd6 && fz);
        end else if (op == 6'd1) begin
            e.cycles   = 5 + dw;
            e.n_aluout = 1;
            e.n_rddm   = dw + 1;
            e.n_lmd    = 1;
            e.n_wrrp   = 1;
            e.wbsel    = 2'b00;
        end else if (op == 6'd2) begin
            e.cycles   = 4 + dw;
            e.n_aluout = 1;
            e.n_wrdm   = dw + 1;
        end else begin
            e.cycles = 4;
            e.n_wrrp = 1;
            if (op == 6'd7) e.wbsel = 2'b10;
            else if (op == 6'd42) e.wbsel = 2'b11;
            else begin
                e.wbsel    = 2'b01;
                e.n_aluout = 1;
                e.aluf     = (op == 6'd0) ? fn : op[3:0];
            end
        end
        e.cycles += iw;
        return e;
    endfunction

    // Runs one instruction starting in FETCH until the cycle that loads the PC.
    task automatic run_instr(input logic [5:0] op, input logic [3:0] fn, input logic fneg,
                             input logic fz, input int iw, input int dw, output stats_t s);
        bit fetched;
        bit done;
        int im_seen;
        int dm_seen;
        fetched = 0;
        done    = 0;
        im_seen = 0;
        dm_seen = 0;
        s       = '0;
        bus.i_flag_n = fneg;
        bus.i_flag_z = fz;
        bus.i_resume = 1'b1;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            bus.i_opcode   = fetched ? op : 6'($urandom);
            bus.i_func     = fetched ? fn : 4'($urandom);
            bus.i_im_ready = (im_seen >= iw);
            bus.i_dm_ready = (dm_seen >= dw);
            #1;
            s.cycles++;
            if (bus.o_rd_im) begin im_seen++; s.n_rdim++; end
            if (bus.o_rd_dm) begin dm_seen++; s.n_rddm++; end
            if (bus.o_wr_dm) begin dm_seen++; s.n_wrdm++; end
            if (bus.o_ld_ir) begin fetched = 1; s.n_ldir++; end
            if (bus.o_wr_rp) begin s.n_wrrp++; s.wbsel = bus.o_wb_sel; end
            if (bus.o_ld_aluout) begin s.n_aluout++; s.aluf = bus.o_alu_func; end
            if (bus.o_illegal) s.n_ill++;
            if (bus.o_ld_lmd) s.n_lmd++;
            if (bus.o_mem_timeout) s.n_tmo++;
            if (bus.o_halted) s.n_halt++;
            if (bus.o_ld_pc) begin s.n_ldpc++; s.pcsel = bus.o_pc_sel; done = 1; end
        end
        if (!done) chk("instr_retire_budget", 0, 1);
    endtask

    task automatic cmp_stats(input string t, input stats_t a, input stats_t e);
        chk({t, "_cycles"}, a.cycles, e.cycles);
        chk({t, "_ld_pc"}, a.n_ldpc, e.n_ldpc);
        chk({t, "_pc_sel"}, a.pcsel, e.pcsel);
        chk({t, "_ld_ir"}, a.n_ldir, e.n_ldir);
        chk({t, "_rd_im"}, a.n_rdim, e.n_rdim);
        chk({t, "_wr_rp"}, a.n_wrrp, e.n_wrrp);
        chk({t, "_wb_sel"}, a.wbsel, e.wbsel);
        chk({t, "_illegal"}, a.n_ill, e.n_ill);
        chk({t, "_ld_aluout"}, a.n_aluout, e.n_aluout);
        chk({t, "_alu_func"}, a.aluf, e.aluf);
        chk({t, "_rd_dm"}, a.n_rddm, e.n_rddm);
        chk({t, "_wr_dm"}, a.n_wrdm, e.n_wrdm);
        chk({t, "_ld_lmd"}, a.n_lmd, e.n_lmd);
        chk({t, "_timeout"}, a.n_tmo, e.n_tmo);
        chk({t, "_halted"}, a.n_halt, e.n_halt);
    endtask

    logic [5:0] ops [14] = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9,
                             6'd42, 6'd48, 6'd57, 6'd63};

    initial begin
        #200000;
        $display("FAIL global_watchdog: actual timeout required finish");
        $fatal(1);
    end

    initial begin
        vec_t   vecs[19];
        stats_t s;
        stats_t e;
        int     n;
        bit     seen;

        //             op      fn    n  z  cyc pcs wr wb     ill aluf
        vecs[0]  = '{6'd0,  4'd5, 0, 0, 4, 0, 1, 2'b01, 0, 4'd5};
        vecs[1]  = '{6'd48, 4'd7, 0, 0, 4, 0, 1, 2'b01, 0, 4'd0};
        vecs[2]  = '{6'd57, 4'd0, 0, 0, 4, 0, 1, 2'b01, 0, 4'd9};
        vecs[3]  = '{6'd63, 4'd2, 0, 0, 4, 0, 1, 2'b01, 0, 4'd15};
        vecs[4]  = '{6'd1,  4'd3, 0, 0, 5, 0, 1, 2'b00, 0, 4'd0};
        vecs[5]  = '{6'd2,  4'd3, 0, 0, 4, 0, 0, 2'b00, 0, 4'd0};
        vecs[6]  = '{6'd3,  4'd1, 0, 0, 3, 1, 0, 2'b00, 0, 4'd0};
        vecs[7]  = '{6'd4,  4'd0, 1, 0, 3, 1, 0, 2'b00, 0, 4'd0};
        vecs[8]  = '{6'd4,  4'd0, 0, 1, 3, 0, 0, 2'b00, 0, 4'd0};
        vecs[9]  = '{6'd5,  4'd0, 0, 0, 3, 1, 0, 2'b00, 0, 4'd0};
        vecs[10] = '{6'd5,  4'd0, 0, 1, 3, 0, 0, 2'b00, 0, 4'd0};
        vecs[11] = '{6'd6,  4'd0, 0, 1, 3, 1, 0, 2'b00, 0, 4'd0};
        vecs[12] = '{6'd6,  4'd0, 1, 0, 3, 0, 0, 2'b00, 0, 4'd0};
        vecs[13] = '{6'd7,  4'd9, 0, 0, 4, 0, 1, 2'b10, 0, 4'd0};
        vecs[14] = '{6'd42, 4'd9, 0, 0, 4, 0, 1, 2'b11, 0, 4'd0};
        vecs[15] = '{6'd9,  4'd0, 0, 0, 2, 0, 0, 2'b00, 0, 4'd0};
        vecs[16] = '{6'd15, 4'd0, 0, 0, 2, 0, 0, 2'b00, 1, 4'd0};
        vecs[17] = '{6'd8,  4'd0, 0, 0, 3, 0, 0, 2'b00, 0, 4'd0};
        vecs[18] = '{6'd11, 4'd0, 1, 1, 2, 0, 0, 2'b00, 1, 4'd0};

        n_chk = 0;
        n_fail = 0;
        rst = 1'b1;
        bus.i_opcode = '0; bus.i_func = '0; bus.i_im_ready = 1'b1; bus.i_dm_ready = 1'b1;
        bus.i_flag_n = 1'b1; bus.i_flag_z = 1'b1; bus.i_resume = 1'b1;

        repeat (2) @(negedge clk);
        #1 chk("reset_outputs_quiet", outs(), 0);
        @(negedge clk);
        rst = 1'b0;
        bus.i_im_ready = 1'b0;
        #1 chk("rd_im_after_reset", {bus.o_rd_im, bus.o_ld_ir, bus.o_ld_npc}, 3'b100);

        foreach (vecs[i]) begin
            run_instr(vecs[i].op, vecs[i].fn, vecs[i].fneg, vecs[i].fz, 0, 0, s);
            chk($sformatf("vec%0d_cycles", i), s.cycles, vecs[i].cycles);
            chk($sformatf("vec%0d_ld_pc_once", i), s.n_ldpc, 1);
            chk($sformatf("vec%0d_pc_sel", i), s.pcsel, vecs[i].pcsel);
            chk($sformatf("vec%0d_wr_rp", i), s.n_wrrp, vecs[i].wrrp);
            chk($sformatf("vec%0d_wb_sel", i), s.wbsel, vecs[i].wbsel);
            chk($sformatf("vec%0d_illegal", i), s.n_ill, vecs[i].ill);
            chk($sformatf("vec%0d_alu_func", i), s.aluf, vecs[i].aluf);
        end

        // LD with three data wait states: rd_dm for four cycles, eight cycles in total.
        run_instr(6'd1, 4'd0, 0, 0, 0, 3, s);
        chk("ld_wait3_cycles", s.cycles, 8);
        chk("ld_wait3_rd_dm", s.n_rddm, 4);
        chk("ld_wait3_ld_lmd", s.n_lmd, 1);

        // ST with data memory stuck: fifteen wr_dm cycles, then timeout into HALT.
        bus.i_resume = 1'b0; bus.i_im_ready = 1'b1; bus.i_dm_ready = 1'b0;
        bus.i_opcode = 6'd2; bus.i_func = '0;
        n = 0; s = '0; seen = 0;
        for (int c = 0; c < 60 && !seen; c++) begin
            @(negedge clk);
            #1;
            if (bus.o_wr_dm) n++;
            if (bus.o_mem_timeout) begin
                s.n_tmo++;
                chk("tmo_strobe_dropped", bus.o_wr_dm, 0);
            end
            if (bus.o_halted) seen = 1;
        end
        chk("tmo_wr_dm_cycles", n, 15);
        chk("tmo_pulse_count", s.n_tmo, 1);
        chk("tmo_halted", seen, 1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1 chk("halt_hold", {bus.o_halted, bus.o_ld_pc, bus.o_rd_im}, 3'b100);
        end
        @(negedge clk);
        bus.i_resume = 1'b1;
        #1 chk("resume_ld_pc", {bus.o_halted, bus.o_ld_pc, bus.o_pc_sel}, 3'b110);
        @(negedge clk);
        bus.i_resume = 1'b0;
        #1 chk("resume_to_fetch", {bus.o_rd_im, bus.o_halted}, 2'b10);

        // Reset in the middle of an LD memory wait.
        bus.i_opcode = 6'd1; bus.i_dm_ready = 1'b0; bus.i_im_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            #1 if (bus.o_rd_dm) seen = 1;
        end
        chk("ld_reached_mem", seen, 1);
        @(negedge clk);
        #1 chk("ld_still_waiting", bus.o_rd_dm, 1);
        #2 rst = 1'b1;
        #1 chk("rst_mid_mem_quiet", outs(), 0);
        @(negedge clk);
        bus.i_dm_ready = 1'b1;
        #1 chk("rst_held_no_ld_lmd", outs(), 0);
        @(negedge clk);
        rst = 1'b0;
        bus.i_im_ready = 1'b0;
        #1 chk("rst_release_fetch", {bus.o_rd_im, bus.o_rd_dm, bus.o_ld_lmd}, 3'b100);
        run_instr(6'd48, 4'd0, 0, 0, 1, 0, s);
        e = model(6'd48, 4'd0, 0, 0, 1, 0);
        cmp_stats("post_rst_addi", s, e);

        for (int k = 0; k < 60; k++) begin
            logic [5:0] op;
            logic [3:0] fn;
            logic       fneg;
            logic       fz;
            int         iw;
            int         dw;
            op   = ($urandom_range(0, 3) == 0) ? 6'($urandom) : ops[$urandom_range(0, 13)];
            fn   = 4'($urandom);
            fneg = 1'($urandom);
            fz   = 1'($urandom);
            iw   = $urandom_range(0, 3);
            dw   = $urandom_range(0, 5);
            run_instr(op, fn, fneg, fz, iw, dw, s);
            e = model(op, fn, fneg, fz, iw, dw);
            cmp_stats($sformatf("rnd%0d_op%0d", k, op), s, e);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_control_unit.md
SEQ_CONTROL_UNIT -- requirements
Module: seq_control_unit

Interface
REQ-001 Parameters SHALL be: OPW, default 6, opcode width; FUNCW, default 4, ALU function width; TOW, default 4, memory-wait timeout counter width.
REQ-002 Ports SHALL be: clk in 1 clock; rst in 1 reset, asynchronous, active-high.
REQ-003 Inputs SHALL be: opcode in OPW, from IR; func in FUNCW, from IR; im_ready in 1, instruction memory done; dm_ready in 1, data memory done; flag_n in 1, A negative; flag_z in 1, A zero; resume in 1, leave halt.
REQ-004 Outputs SHALL be 1 bit each: rd_im, ld_npc, ld_ir, rd_rp, ld_a, ld_b, ld_imm, imm_sel, alu_src1, alu_src2, ld_aluout, rd_dm, wr_dm, ld_lmd, wr_rp, ld_pc, pc_sel (1 = ALUOut, 0 = NPC), halted, illegal (1-cycle pulse), mem_timeout (1-cycle pulse).
REQ-005 Multi-bit outputs SHALL be: alu_func, FUNCW bits; wb_sel, 2 bits (00 LMD, 01 ALUOut, 10 MOVE path, 11 CMOV path).

Function
REQ-006 Opcode classes SHALL be: ALU 000000; LD 000001; ST 000010; BR 000011; BMI 000100; BPL 000101; BZ 000110; MOVE 000111; HALT 001000; NOP 001001; CMOV 101010; IMM 110000-111001 and LUI 111111. Opcodes are zero-extended when OPW>6. Any other opcode is illegal.
REQ-007 FSM states SHALL be FETCH, DECODE, EXEC, MEM, WB, HALT, and all outputs SHALL be combinational from state and inputs (Moore-style plus ready gating).
REQ-008 In FETCH, rd_im SHALL be held at 1. ld_npc and ld_ir SHALL be 1 only in the cycle im_ready=1, and FETCH→DECODE SHALL occur on that cycle.
REQ-009 In DECODE, ALU SHALL assert rd_rp, ld_a, ld_b. IMM/LUI/BMI/BPL/BZ SHALL assert rd_rp, ld_a, ld_imm. LD/ST SHALL assert rd_rp, ld_a, ld_b, ld_imm. BR SHALL assert ld_imm, imm_sel. MOVE SHALL assert ld_a. CMOV SHALL assert ld_a, ld_b.
REQ-010 In DECODE, HALT SHALL go to HALT. NOP SHALL assert ld_pc with pc_sel=0 and go to FETCH. Illegal opcodes SHALL pulse illegal, then behave as NOP.
REQ-011 In EXEC, ld_aluout SHALL be 1 for ALU/IMM/LUI/LD/ST/branches, and alu_src2=1 for every class except ALU.
REQ-012 EXEC alu_func SHALL be: func for ALU; opcode[3:0] zero-extended to FUNCW for IMM/LUI; 0 (add) for LD/ST/branches.
REQ-013 In EXEC, alu_src1 SHALL be 1 for branches.
REQ-014 EXEC next state SHALL be: LD/ST→MEM; ALU/IMM/LUI/MOVE/CMOV→WB.
REQ-015 Branches SHALL complete in EXEC with ld_pc=1 and go to FETCH. pc_sel SHALL be 1 for BR; for BMI if flag_n; for BPL if !flag_n && !flag_z; for BZ if flag_z; otherwise 0.
REQ-016 In MEM, rd_dm (LD) or wr_dm (ST) SHALL be held until dm_ready=1.
REQ-017 On the dm_ready cycle, LD SHALL assert ld_lmd and go to WB. ST SHALL assert ld_pc with pc_sel=0 and go to FETCH.
REQ-018 A TOW-bit wait counter SHALL clear on entry to FETCH and MEM and increment each cycle ready=0. On reaching 2^TOW-1 with ready still 0, the block SHALL pulse mem_timeout, deassert the memory strobe and go to HALT.
REQ-019 In WB, wr_rp=1, ld_pc=1, pc_sel=0, then go to FETCH. wb_sel SHALL be: 00 LD, 01 ALU/IMM/LUI, 10 MOVE, 11 CMOV.
REQ-020 In HALT, halted SHALL be 1 and all other strobes 0. resume=1 SHALL go to FETCH next cycle with ld_pc=1, pc_sel=0 asserted in that HALT cycle.
REQ-021 Per-class cycle counts with zero wait states SHALL be: branches 3; NOP/illegal 2; ALU/IMM/MOVE/CMOV 4; ST 4; LD 5.
REQ-022 ld_pc SHALL be asserted exactly once per retired instruction.
REQ-023 opcode and func SHALL be sampled only in DECODE onward. A change of opcode/func during FETCH SHALL have no effect.

Reset
REQ-024 rst SHALL force state FETCH and wait counter 0 asynchronously, overriding any in-progress MEM wait or HALT.
REQ-025 While rst=1, all strobes, halted, illegal, mem_timeout SHALL be 0, alu_func=0 and wb_sel=00. rd_im SHALL rise in the first cycle after rst deasserts.

Verification
REQ-026 ADDI (110000), im_ready=dm_ready=1 → 4 cycles. EXEC shows alu_func=0000, alu_src2=1. WB shows wr_rp=1, wb_sel=01, ld_pc=1.
REQ-027 LD with dm_ready low for 3 cycles → rd_dm high 4 cycles, ld_lmd on 4th. WB shows wb_sel=00. Total 8 cycles.
REQ-028 BZ with flag_z=1 → EXEC ld_pc=1, pc_sel=1. With flag_z=0 → pc_sel=0. Both take 3 cycles, no wr_rp.
REQ-029 TOW=4, ST with dm_ready stuck 0 → wr_dm high 15 cycles, mem_timeout pulse, halted=1. resume → FETCH.
REQ-030 Opcode 001111 → illegal pulse in DECODE, ld_pc/pc_sel=0, back in FETCH after 2 cycles.
REQ-031 rst asserted mid-MEM wait of LD → outputs 0 immediately, no ld_lmd. After release, FETCH with rd_im=1.
